// File: rtl/fib_req_master.sv
// fib_req_master -- initiator side of the Fibonacci engine handshake.
//
// Buffers index requests from a valid/ready stream in a small FIFO. Each
// request becomes one engine transaction: a one-cycle go pulse with n held
// stable. The engine's result/overflow are captured on done and returned on
// a valid/ready response stream tagged with the index that produced them.
//
// Ports:
//   clk, rst            clock; synchronous active-high reset
//   req_valid/req_ready request stream handshake, req_n = Fibonacci index
//   go, n               engine start pulse and index presented to the engine
//   done, result,       engine completion and its payload
//   overflow
//   rsp_valid/rsp_ready response stream handshake
//   rsp_n, rsp_result,  index, captured result, captured overflow flag
//   rsp_overflow
//   rsp_timeout         response was produced by the watchdog, not the engine
//   busy                transaction in flight or requests still queued
//
// Build option: define FIB_REQ_TIMEOUT_EN to add a watchdog that aborts a
// WAIT lasting TIMEOUT_CYCLES cycles. Without it, WAIT waits forever and
// rsp_timeout is constant 0.
`timescale 1ns/1ps
module fib_req_master #(
  parameter int INPUT_WIDTH    = 6,
  parameter int OUTPUT_WIDTH   = 32,
  parameter int FIFO_DEPTH     = 4,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    req_valid,
  input  logic [INPUT_WIDTH-1:0]  req_n,
  output logic                    req_ready,
  output logic                    go,
  output logic [INPUT_WIDTH-1:0]  n,
  input  logic                    done,
  input  logic [OUTPUT_WIDTH-1:0] result,
  input  logic                    overflow,
  output logic                    rsp_valid,
  output logic [INPUT_WIDTH-1:0]  rsp_n,
  output logic [OUTPUT_WIDTH-1:0] rsp_result,
  output logic                    rsp_overflow,
  output logic                    rsp_timeout,
  input  logic                    rsp_ready,
  output logic                    busy
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT,
    S_RESP
  } state_t;

  state_t state, state_nxt;

  // ---------------------------------------------------------------------------
  // Request FIFO
  // ---------------------------------------------------------------------------
  logic [INPUT_WIDTH-1:0] mem [FIFO_DEPTH];
  logic [PTR_W-1:0]       wr_ptr, rd_ptr;
  logic [CNT_W-1:0]       count;
  logic                   full, empty, push, pop;

  assign full      = (count == CNT_W'(FIFO_DEPTH));
  assign empty     = (count == '0);
  // Ready is registered fullness only: a pop in the same cycle does not open
  // a slot until the next cycle.
  assign req_ready = !full;
  assign push      = req_valid && !full;
  assign pop       = (state == S_IDLE) && !empty;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values of the others, independent of block order.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      // Power-of-two depth: pointers wrap by natural overflow.
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // NOTE: the storage array is deliberately not reset; count guards every
  // read, so stale contents are never observed and the array can map to RAM.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= req_n;
  end

  // ---------------------------------------------------------------------------
  // Optional watchdog
  // ---------------------------------------------------------------------------
  logic timeout_hit;

`ifdef FIB_REQ_TIMEOUT_EN
  localparam int WD_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [WD_W-1:0] wdog;

  // wdog holds (WAIT cycles elapsed - 1), so the abort fires on WAIT cycle
  // number TIMEOUT_CYCLES. done in that same cycle takes priority.
  assign timeout_hit = (state == S_WAIT) && !done &&
                       (wdog == WD_W'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      wdog        <= '0;
      rsp_timeout <= 1'b0;
    end else begin
      if (state == S_ISSUE)     wdog <= '0;
      else if (state == S_WAIT) wdog <= wdog + 1'b1;

      if ((state == S_WAIT) && done) rsp_timeout <= 1'b0;
      else if (timeout_hit)          rsp_timeout <= 1'b1;
    end
  end
`else
  assign timeout_hit = 1'b0;
  assign rsp_timeout = 1'b0;
`endif

  // ---------------------------------------------------------------------------
  // FSM: state register / next state / outputs
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  // NOTE: the default assignment at the top keeps this block purely
  // combinational; a path that left state_nxt unassigned would infer a latch.
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (!empty) state_nxt = S_ISSUE;
      S_ISSUE: state_nxt = S_WAIT;  // done is not looked at here
      S_WAIT:  if (done || timeout_hit) state_nxt = S_RESP;
      S_RESP:  if (rsp_ready) state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    go        = (state == S_ISSUE);
    rsp_valid = (state == S_RESP);
    busy      = (state != S_IDLE) || !empty;
  end

  // ---------------------------------------------------------------------------
  // Datapath: engine index and captured response
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      n            <= '0;
      rsp_n        <= '0;
      rsp_result   <= '0;
      rsp_overflow <= 1'b0;
    end else begin
      if (pop) n <= mem[rd_ptr];

      if ((state == S_WAIT) && done) begin
        rsp_n        <= n;
        rsp_result   <= result;
        rsp_overflow <= overflow;
      end else if (timeout_hit) begin
        rsp_n        <= n;
        rsp_result   <= '0;
        rsp_overflow <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_fib_req_master.sv
// tb_fib_req_master -- directed self-checking bench for fib_req_master.
// A behavioural engine answers go pulses with Fibonacci values after a
// programmable delay; a second manual done source injects stray or precisely
// timed completions. Expected values are hand-computed constants.
`timescale 1ns/1ps
module tb_fib_req_master;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_valid = 1'b0;
  logic [5:0]  req_n = '0;
  logic        req_ready;
  logic        go;
  logic [5:0]  n;
  logic        done;
  logic [31:0] result;
  logic        overflow;
  logic        rsp_valid;
  logic [5:0]  rsp_n;
  logic [31:0] rsp_result;
  logic        rsp_overflow;
  logic        rsp_timeout;
  logic        rsp_ready = 1'b1;
  logic        busy;

  always #5 clk = ~clk;

  fib_req_master #(
    .INPUT_WIDTH   (6),
    .OUTPUT_WIDTH  (32),
    .FIFO_DEPTH    (4),
    .TIMEOUT_CYCLES(8)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .req_valid   (req_valid),
    .req_n       (req_n),
    .req_ready   (req_ready),
    .go          (go),
    .n           (n),
    .done        (done),
    .result      (result),
    .overflow    (overflow),
    .rsp_valid   (rsp_valid),
    .rsp_n       (rsp_n),
    .rsp_result  (rsp_result),
    .rsp_overflow(rsp_overflow),
    .rsp_timeout (rsp_timeout),
    .rsp_ready   (rsp_ready),
    .busy        (busy)
  );

  // Two done sources: the behavioural engine and manual injection.
  logic        done_eng = 1'b0, done_man = 1'b0;
  logic [31:0] res_eng = '0, res_man = '0;
  logic        ovf_eng = 1'b0, ovf_man = 1'b0;
  assign done     = done_eng | done_man;
  assign result   = done_man ? res_man : res_eng;
  assign overflow = done_man ? ovf_man : ovf_eng;

  function automatic logic [63:0] fib64(input int k);
    logic [63:0] a, b, t;
    a = 64'd0;
    b = 64'd1;
    for (int i = 0; i < k; i++) begin
      t = a + b;
      a = b;
      b = t;
    end
    return a;
  endfunction

  bit          engine_en    = 1'b1;
  int          engine_delay = 10;
  logic [63:0] eng_val;

  initial begin
    forever begin
      @(negedge clk);
      if (go && engine_en) begin
        eng_val = fib64(int'(n));
        repeat (engine_delay) @(negedge clk);
        done_eng = 1'b1;
        res_eng  = eng_val[31:0];
        ovf_eng  = (eng_val[63:32] != 32'd0);
        @(negedge clk);
        done_eng = 1'b0;
        res_eng  = '0;
        ovf_eng  = 1'b0;
      end
    end
  end

  int go_count = 0;
  always @(negedge clk) if (go) go_count++;

  typedef struct {
    logic [5:0]  n;
    logic [31:0] r;
    logic        o;
    logic        t;
  } rsp_t;
  rsp_t rsp_q[$];

  always @(negedge clk) begin
    rsp_t e;
    if (rsp_valid && rsp_ready) begin
      e.n = rsp_n;
      e.r = rsp_result;
      e.o = rsp_overflow;
      e.t = rsp_timeout;
      rsp_q.push_back(e);
    end
  end

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic push(input logic [5:0] v);
    bit ok;
    ok        = 1'b0;
    req_valid = 1'b1;
    req_n     = v;
    for (int i = 0; i < 200; i++) begin
      if (req_ready) begin
        ok = 1'b1;
        @(negedge clk);
        break;
      end
      @(negedge clk);
    end
    req_valid = 1'b0;
    check("push_accept", 64'(ok), 64'd1);
  endtask

  task automatic wait_rsps(input int target, input int budget);
    for (int i = 0; i < budget && rsp_q.size() < target; i++) begin
      @(negedge clk);
      #1;
    end
    check("rsp_count", 64'(rsp_q.size()), 64'(target));
  endtask

  task automatic wait_go(input int budget);
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (go) break;
    end
    check("go_seen", 64'(go), 64'd1);
  endtask

  task automatic check_rsp(input int idx, input logic [5:0] en, input logic [31:0] er,
                           input logic eo, input logic et);
    check("rsp_present", 64'(idx < rsp_q.size()), 64'd1);
    if (idx < rsp_q.size()) begin
      check("rsp_n",        64'(rsp_q[idx].n), 64'(en));
      check("rsp_result",   64'(rsp_q[idx].r), 64'(er));
      check("rsp_overflow", 64'(rsp_q[idx].o), 64'(eo));
      check("rsp_timeout",  64'(rsp_q[idx].t), 64'(et));
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_req_ready"},    64'(req_ready),    64'd1);
    check({tag, "_go"},           64'(go),           64'd0);
    check({tag, "_n"},            64'(n),            64'd0);
    check({tag, "_rsp_valid"},    64'(rsp_valid),    64'd0);
    check({tag, "_rsp_n"},        64'(rsp_n),        64'd0);
    check({tag, "_rsp_result"},   64'(rsp_result),   64'd0);
    check({tag, "_rsp_overflow"}, 64'(rsp_overflow), 64'd0);
    check({tag, "_rsp_timeout"},  64'(rsp_timeout),  64'd0);
    check({tag, "_busy"},         64'(busy),         64'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "global timeout");
  end

  logic [31:0] fib_exp [6] = '{32'd1, 32'd1, 32'd2, 32'd3, 32'd5, 32'd8};
  int g0;

  initial begin
    // ---- Reset -----------------------------------------------------------
    repeat (2) @(negedge clk);
    rst = 1'b0;
    check_reset_outputs("reset");

    // ---- Single request n=10 --------------------------------------------
    engine_delay = 10;
    g0 = go_count;
    req_valid = 1'b1;
    req_n     = 6'd10;
    @(negedge clk);
    req_valid = 1'b0;
    check("t1_busy_queued", 64'(busy), 64'd1);
    check("t1_go_early", 64'(go), 64'd0);
    @(negedge clk);
    check("t1_go", 64'(go), 64'd1);
    check("t1_n", 64'(n), 64'd10);
    wait_rsps(1, 40);
    check_rsp(0, 6'd10, 32'd55, 1'b0, 1'b0);
    @(negedge clk);
    check("t1_rsp_valid_drop", 64'(rsp_valid), 64'd0);
    check("t1_busy_idle", 64'(busy), 64'd0);
    check("t1_go_pulses", 64'(go_count - g0), 64'd1);

    // ---- Boundaries: n=0, 47, 48 ----------------------------------------
    engine_delay = 3;
    push(6'd0);
    push(6'd47);
    push(6'd48);
    wait_rsps(4, 100);
    check_rsp(1, 6'd0,  32'd0,          1'b0, 1'b0);
    check_rsp(2, 6'd47, 32'd2971215073, 1'b0, 1'b0);
    check_rsp(3, 6'd48, 32'd512559680,  1'b1, 1'b0);

    // ---- Backpressure and full FIFO -------------------------------------
    @(negedge clk);
    rsp_ready    = 1'b0;
    engine_delay = 2;
    g0 = go_count;
    push(6'd1);
    for (int i = 0; i < 30; i++) begin
      if (rsp_valid) break;
      @(negedge clk);
    end
    check("t3_rsp_valid", 64'(rsp_valid), 64'd1);
    for (int k = 2; k <= 5; k++) push(6'(k));
    check("t3_full_ready", 64'(req_ready), 64'd0);
    req_valid = 1'b1;
    req_n     = 6'd6;
    repeat (3) @(negedge clk);
    check("t3_still_full", 64'(req_ready), 64'd0);
    check("t3_hold_valid", 64'(rsp_valid), 64'd1);
    check("t3_hold_n", 64'(rsp_n), 64'd1);
    check("t3_hold_result", 64'(rsp_result), 64'd1);
    check("t3_hold_overflow", 64'(rsp_overflow), 64'd0);
    check("t3_busy", 64'(busy), 64'd1);
    check("t3_no_accept", 64'(rsp_q.size()), 64'd4);
    rsp_ready = 1'b1;
    push(6'd6);
    wait_rsps(10, 200);
    for (int k = 0; k < 6; k++) check_rsp(4 + k, 6'(k + 1), fib_exp[k], 1'b0, 1'b0);
    check("t3_go_pulses", 64'(go_count - g0), 64'd6);

    // ---- Stray done in IDLE and ISSUE -----------------------------------
    @(negedge clk);
    check("t4_idle", 64'(busy), 64'd0);
    done_man = 1'b1;
    res_man  = 32'hDEAD;
    @(negedge clk);
    done_man = 1'b0;
    repeat (3) @(negedge clk);
    check("t4_idle_done_ignored", 64'(rsp_q.size()), 64'd10);
    check("t4_idle_rsp_valid", 64'(rsp_valid), 64'd0);
    engine_en = 1'b0;
    push(6'd7);
    wait_go(10);
    done_man = 1'b1;
    res_man  = 32'd999;
    @(negedge clk);
    done_man = 1'b0;
    repeat (3) @(negedge clk);
    check("t4_issue_done_ignored", 64'(rsp_valid), 64'd0);
    done_man = 1'b1;
    res_man  = 32'd13;
    @(negedge clk);
    done_man = 1'b0;
    check("t4_rsp_latency", 64'(rsp_valid), 64'd1);
    wait_rsps(11, 20);
    repeat (5) @(negedge clk);
    check("t4_single_rsp", 64'(rsp_q.size()), 64'd11);
    check_rsp(10, 6'd7, 32'd13, 1'b0, 1'b0);

    // ---- Reset mid-WAIT --------------------------------------------------
    engine_en    = 1'b1;
    engine_delay = 20;
    push(6'd9);
    wait_go(10);
    repeat (5) @(negedge clk);
    check("t5_waiting", 64'(busy), 64'd1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check_reset_outputs("midrst");
    repeat (25) @(negedge clk);
    check("t5_late_done_ignored", 64'(rsp_q.size()), 64'd11);
    check("t5_rsp_valid", 64'(rsp_valid), 64'd0);
    check("t5_busy", 64'(busy), 64'd0);
    engine_delay = 4;
    push(6'd10);
    wait_rsps(12, 40);
    check_rsp(11, 6'd10, 32'd55, 1'b0, 1'b0);

`ifdef FIB_REQ_TIMEOUT_EN
    // ---- Watchdog abort and done/timeout tie ----------------------------
    @(negedge clk);
    engine_en = 1'b0;
    push(6'd5);
    wait_go(10);
    repeat (8) @(negedge clk);
    check("t6_before_timeout", 64'(rsp_valid), 64'd0);
    @(negedge clk);
    check("t6_timeout_valid", 64'(rsp_valid), 64'd1);
    check("t6_timeout_flag", 64'(rsp_timeout), 64'd1);
    wait_rsps(13, 20);
    check_rsp(12, 6'd5, 32'd0, 1'b0, 1'b1);
    @(negedge clk);
    push(6'd6);
    wait_go(10);
    repeat (8) @(negedge clk);
    done_man = 1'b1;
    res_man  = 32'd8;
    ovf_man  = 1'b0;
    @(negedge clk);
    done_man = 1'b0;
    check("t6_tie_valid", 64'(rsp_valid), 64'd1);
    wait_rsps(14, 20);
    check_rsp(13, 6'd6, 32'd8, 1'b0, 1'b0);
`endif

    repeat (2) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
